operand_entry_ctrl: RTL and testbench
=====================================

// Module: operand_entry_ctrl
// PURPOSE
//  Input side of the 4-bit add/sub calculator. Debounces three push-buttons
//  and turns each press into a single-cycle pulse. A small FSM uses those
//  pulses to build operands A and B and the add/sub mode. Its outputs drive
//  the adder/subtractor operand and mode inputs, and the FND driver enable.
// PARAMETERS
//  DEBOUNCE_CYCLES  100000  consecutive stable cycles before a level change is accepted (>=1)
//  WIDTH            4       operand width in bits
// PORTS
//  i_clk       in   1      system clock, rising edge
//  i_reset_n   in   1      asynchronous active-low reset
//  i_btn_up    in   1      raw button: increment the operand being edited
//  i_btn_next  in   1      raw button: advance the FSM
//  i_btn_mode  in   1      raw button: toggle add/sub
//  o_a         out  WIDTH  operand A
//  o_b         out  WIDTH  operand B
//  o_mode      out  1      0 = add, 1 = subtract
//  o_en        out  1      display enable; 1 only in S_RESULT
//  o_state     out  2      current FSM state encoding
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Outputs: o_a=0, o_b=0, o_mode=0, o_en=0, o_state=S_A.
//   - Internals: synchronisers, debounced levels and debounce counters cleared to 0.
//  Per-button conditioning (three identical instances):
//   - 2-FF synchroniser, then debouncer.
//   - Counter increments while the synced input differs from the debounced level.
//   - Counter clears whenever the synced input equals the debounced level.
//   - When the counter reaches DEBOUNCE_CYCLES: debounced level flips, counter clears.
//   - Press pulse = 1 cycle on a debounced 0->1 transition. Releases generate no pulse.
//   - A raw glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
//   - Holding a button produces exactly one pulse.
//  Latency:
//   - Raw input rises before edge N and stays high.
//   - Pulse is high in cycle N+DEBOUNCE_CYCLES+2.
//   - Registered outputs change at edge N+DEBOUNCE_CYCLES+3.
//  FSM states: S_A=2'b00, S_B=2'b01, S_RESULT=2'b10. 2'b11 is illegal and recovers to S_A.
//   - up pulse:
//       S_A: o_a <= o_a+1 (mod 2^WIDTH; 15 wraps to 0).
//       S_B: o_b <= o_b+1 (same wrap rule).
//       S_RESULT: ignored.
//   - next pulse: S_A->S_B, S_B->S_RESULT, S_RESULT->S_A. o_a and o_b are retained.
//   - mode pulse: toggles o_mode in any state.
//   - o_en is a registered state decode: 1 in the same cycle the state becomes S_RESULT.
//  Simultaneous pulses in one cycle:
//   - next beats up: the transition happens and the increment is dropped.
//   - mode is applied in addition to either.
//  Reset asserted mid-debounce or mid-entry: everything returns to reset values.
//   No pulse is produced from a press that was in progress when reset asserted.
// TESTING (bench runs with DEBOUNCE_CYCLES=4)
//  1. Reset: hold i_reset_n=0 with buttons toggling
//     -> o_a=0, o_b=0, o_mode=0, o_en=0, o_state=00.
//  2. Raw i_btn_up high for 3 cycles, then low -> no change. High for 10 cycles
//     -> o_a goes 0->1 exactly at edge 7 after the rise, and only once.
//  3. Sixteen clean up presses in S_A -> o_a counts 1..15, then wraps to 0. o_b unchanged.
//  4. Sequence next, 3x up, next -> o_state 01 with o_b=3, then 10 with o_en=1.
//     One more next -> o_state 00, o_en=0, o_a and o_b held.
//  5. up and next debounced in the same cycle while in S_A, with o_a=5
//     -> o_state=01, o_a stays 5. Same with mode added -> o_mode also toggles.
//  6. Assert reset 2 cycles into a press debounce -> outputs at reset values,
//     and no pulse appears after reset releases.

Source files
------------

// File: rtl/operand_entry_ctrl.sv
// Operand entry front end for the 4-bit add/sub calculator.
// Synchronises and debounces the buttons, then builds A, B and the add/sub mode.
module operand_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int WIDTH           = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_up,
  input  logic             i_btn_next,
  input  logic             i_btn_mode,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_mode,
  output logic             o_en,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_A      = 2'b00,
    S_B      = 2'b01,
    S_RESULT = 2'b10
  } state_t;

  state_t     state;
  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {i_btn_mode, i_btn_next, i_btn_up};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic          sync1;
    logic          sync2;
    logic          level;
    logic          pulse;
    logic [CW-1:0] cnt;

    // The counter only survives while the synced input keeps disagreeing with
    // the accepted level, so any shorter glitch is discarded.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        level <= 1'b0;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        pulse <= 1'b0;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          level <= ~level;
          cnt   <= '0;
          pulse <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[g] = pulse;
  end

  // next takes priority over up; mode toggles independently of both.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= S_A;
      o_a    <= '0;
      o_b    <= '0;
      o_mode <= 1'b0;
      o_en   <= 1'b0;
    end else begin
      if (press[2]) o_mode <= ~o_mode;
      case (state)
        S_A: begin
          if (press[1]) state <= S_B;
          else if (press[0]) o_a <= o_a + 1'b1;
        end
        S_B: begin
          if (press[1]) begin
            state <= S_RESULT;
            o_en  <= 1'b1;
          end else if (press[0]) begin
            o_b <= o_b + 1'b1;
          end
        end
        S_RESULT: begin
          if (press[1]) begin
            state <= S_A;
            o_en  <= 1'b0;
          end
        end
        default: begin
          state <= S_A;
          o_en  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl: directed scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_operand_entry_ctrl;

  localparam int D = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up, nxt, mode_btn;
  logic [W-1:0] o_a, o_b;
  logic         o_mode, o_en;
  logic [1:0]   o_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_a, m_b;
  logic         m_mode;
  int           m_state;
  bit   [2:0]   hist[$];
  bit   [2:0]   m_lvl;
  int           m_run[3];
  bit   [2:0]   m_pend;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_btn_up(up), .i_btn_next(nxt), .i_btn_mode(mode_btn),
    .o_a(o_a), .o_b(o_b), .o_mode(o_mode), .o_en(o_en), .o_state(o_state)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_a = '0; m_b = '0; m_mode = 1'b0; m_state = 0;
    hist.delete();
    hist.push_back(3'b000);
    hist.push_back(3'b000);
    m_lvl = '0; m_pend = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endfunction

  // A button is accepted after its input (two edges late) has disagreed with
  // the accepted level for D+1 consecutive edges; a press acts one edge later.
  function automatic void modelEdge();
    bit [2:0] delayed, fresh;
    if (m_pend[1]) m_state = (m_state + 1) % 3;
    else if (m_pend[0]) begin
      if (m_state == 0) m_a = m_a + 1'b1;
      else if (m_state == 1) m_b = m_b + 1'b1;
    end
    if (m_pend[2]) m_mode = ~m_mode;
    hist.push_back({mode_btn, nxt, up});
    delayed = hist.pop_front();
    fresh = '0;
    for (int i = 0; i < 3; i++) begin
      if (delayed[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          fresh[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pend = fresh;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".a"}, 32'(o_a), 32'(m_a));
    checkOutput({tag, ".b"}, 32'(o_b), 32'(m_b));
    checkOutput({tag, ".mode"}, 32'(o_mode), 32'(m_mode));
    checkOutput({tag, ".en"}, 32'(o_en), (m_state == 2) ? 32'd1 : 32'd0);
    checkOutput({tag, ".state"}, 32'(o_state), 32'(m_state));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelEdge();
    #1;
    checkAll("cycle");
  endtask

  task automatic applyStimulus(input bit [2:0] btns, input int cycles);
    {mode_btn, nxt, up} = btns;
    repeat (cycles) step();
  endtask

  task automatic pressButtons(input bit [2:0] btns);
    applyStimulus(btns, 8);
    applyStimulus(3'b000, 8);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".a"}, 32'(o_a), 32'd0);
    checkOutput({tag, ".b"}, 32'(o_b), 32'd0);
    checkOutput({tag, ".mode"}, 32'(o_mode), 32'd0);
    checkOutput({tag, ".en"}, 32'(o_en), 32'd0);
    checkOutput({tag, ".state"}, 32'(o_state), 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    {mode_btn, nxt, up} = 3'b000;
    modelReset();
    #1;
    checkResetValues("rst");
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {mode_btn, nxt, up} = 3'b000;
    modelReset();

    $display("[TB] reset with toggling buttons");
    repeat (6) begin
      {mode_btn, nxt, up} = 3'($urandom_range(0, 7));
      step();
    end
    checkResetValues("t1");
    {mode_btn, nxt, up} = 3'b000;
    rst_n = 1'b1;
    applyStimulus(3'b000, 3);

    $display("[TB] glitch rejection and press latency");
    applyStimulus(3'b001, 3);
    applyStimulus(3'b000, 8);
    checkOutput("t2.glitch", 32'(o_a), 32'd0);
    up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("t2.latency", 32'(o_a), (i >= 7) ? 32'd1 : 32'd0);
    end
    applyStimulus(3'b000, 10);
    checkOutput("t2.once", 32'(o_a), 32'd1);

    $display("[TB] sixteen presses with wrap");
    doReset();
    for (int i = 1; i <= 16; i++) begin
      pressButtons(3'b001);
      checkOutput("t3.count", 32'(o_a), 32'(i % 16));
    end
    checkOutput("t3.b", 32'(o_b), 32'd0);

    $display("[TB] entering B and showing the result");
    pressButtons(3'b010);
    checkOutput("t4.stateB", 32'(o_state), 32'd1);
    repeat (3) pressButtons(3'b001);
    checkOutput("t4.b", 32'(o_b), 32'd3);
    checkOutput("t4.a", 32'(o_a), 32'd0);
    pressButtons(3'b010);
    checkOutput("t4.stateR", 32'(o_state), 32'd2);
    checkOutput("t4.enR", 32'(o_en), 32'd1);
    pressButtons(3'b010);
    checkOutput("t4.stateA", 32'(o_state), 32'd0);
    checkOutput("t4.enA", 32'(o_en), 32'd0);
    checkOutput("t4.heldB", 32'(o_b), 32'd3);

    $display("[TB] simultaneous presses");
    repeat (5) pressButtons(3'b001);
    checkOutput("t5.a5", 32'(o_a), 32'd5);
    pressButtons(3'b011);
    checkOutput("t5.state", 32'(o_state), 32'd1);
    checkOutput("t5.aHeld", 32'(o_a), 32'd5);
    checkOutput("t5.bHeld", 32'(o_b), 32'd3);
    repeat (2) pressButtons(3'b010);
    checkOutput("t5.back", 32'(o_state), 32'd0);
    pressButtons(3'b111);
    checkOutput("t5.state2", 32'(o_state), 32'd1);
    checkOutput("t5.aHeld2", 32'(o_a), 32'd5);
    checkOutput("t5.mode", 32'(o_mode), 32'd1);

    $display("[TB] reset during a press debounce");
    applyStimulus(3'b001, 2);
    rst_n = 1'b0;
    up = 1'b0;
    modelReset();
    #1;
    checkResetValues("t6.rst");
    repeat (2) step();
    rst_n = 1'b1;
    applyStimulus(3'b000, 12);
    checkResetValues("t6.after");

    $display("[TB] random button activity");
    repeat (60) applyStimulus(3'($urandom_range(0, 7)), int'($urandom_range(1, 12)));
    applyStimulus(3'b000, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
